sram_fifo_ctrl: RTL
===================

SRAM_FIFO_CTRL -- requirements
Module: sram_fifo_ctrl

Interface
REQ-001 SHALL have parameters: DW, default 8, data width; AW, default 10, SRAM address width; DEPTH, default 1024, SRAM words.
REQ-002 SHALL have ports, one clock, asynchronous active-low reset:
 clk  in  1  single clock, also drives macro clk0 and clk1 at top level
 rst_n  in  1  asynchronous active-low reset
 flush  in  1  synchronous discard of all contents
 push_valid  in  1  write request
 push_ready  out  1  write accept
 push_data  in  DW  write data
 pop_valid  out  1  read data available
 pop_ready  in  1  consumer accept
 pop_data  out  DW  head data
 count  out  AW+1  entries held (SRAM + in-flight + output buffer)
 empty  out  1  count==0
 full  out  1  SRAM region holds DEPTH entries
 sram_csb0  out  1  macro write chip-select, active low
 sram_addr0  out  AW  macro write address
 sram_din0  out  DW  macro write data
 sram_csb1  out  1  macro read chip-select, active low
 sram_addr1  out  AW  macro read address
 sram_dout1  in  DW  macro read data

Function
REQ-003 SHALL accept a push in cycle N iff push_valid && push_ready; push_ready = !full && !flush.
REQ-004 SHALL drive sram_csb0=0, sram_addr0=wptr, sram_din0=push_data combinationally in the accepting cycle; csb0=1 otherwise; wptr increments mod DEPTH.
REQ-005 SHALL keep sram_cnt in the range 0..DEPTH; full = (sram_cnt==DEPTH); push and read-issue in the same cycle leave sram_cnt unchanged.
REQ-006 SHALL make an entry pushed in cycle N eligible for read issue no earlier than cycle N+1, because the macro commits the write on the falling edge after capture.
REQ-007 SHALL issue a read (sram_csb1=0, sram_addr1=rptr) in a cycle iff sram_cnt>0, the output buffer occupancy plus in-flight reads <2, and !flush; rptr increments mod DEPTH.
REQ-008 SHALL capture sram_dout1 into the output buffer at the end of cycle N+1 for a read issued in cycle N, a read latency of 1 cycle.
REQ-009 SHALL never drive sram_csb0=0 and sram_csb1=0 with sram_addr0==sram_addr1 in the same cycle.
REQ-010 SHALL hold a 2-entry in-order output buffer; pop_valid = buffer non-empty; pop_data = buffer head; a pop occurs iff pop_valid && pop_ready.
REQ-011 SHALL keep pop_data stable while pop_valid && !pop_ready.
REQ-012 SHALL sustain 1 push and 1 pop per cycle at steady state with no bubbles once the buffer is primed.
REQ-013 SHALL, for a push into an empty block in cycle N, assert pop_valid from cycle N+3.
REQ-014 SHALL update count each cycle as +1 per push and -1 per pop, simultaneous push and pop giving no change; maximum count is DEPTH+2.
REQ-015 SHALL wrap both pointers from DEPTH-1 to 0 with no lost or duplicated entry.
REQ-016 SHALL, on flush, in the next cycle: zero the pointers, sram_cnt, buffer and count; drop any in-flight read data; deassert pop_valid; hold csb0=csb1=1 during the flush cycle.

Reset
REQ-017 SHALL asynchronously, on rst_n low: clear wptr, rptr, sram_cnt, in-flight flags and the buffer; outputs go to pop_valid=0, empty=1, full=0, count=0, push_ready=0, sram_csb0=1, sram_csb1=1, addresses=0.
REQ-018 SHALL release reset synchronously; push_ready may assert from the first cycle after rst_n rises.
REQ-019 SHALL, on reset mid-operation, discard all contents; the macro contents are don't-care.

Structure
REQ-020 SHALL take DW, AW and DEPTH defaults from the shared package sram_fifo_pkg, which also defines the buffer-occupancy type.
REQ-021 SHALL implement the 2-entry output buffer as sub-module sram_fifo_outbuf (valid/ready in, valid/ready out, occupancy out).
REQ-022 SHALL not instantiate the macro; the macro is instantiated at the top level.

Verification
REQ-023 SHALL cover: reset, then push 0xA5 in cycle 0 -> csb0=0, addr0=0 in cycle 0; csb1=0, addr1=0 in cycle 1; pop_valid=1, pop_data=0xA5 in cycle 3.
REQ-024 SHALL cover: 1026 pushes with pop_ready=0 -> full=1, push_ready=0, count=1026; one pop -> count=1025, full=0 within 2 cycles.
REQ-025 SHALL cover: streaming 3000 incrementing bytes with push and pop active every cycle -> in-order output and pointer wrap at 1023->0; a scoreboard flags no collision per REQ-009.
REQ-026 SHALL cover: random pop_ready backpressure at 30% duty -> pop_data stable while stalled and no loss.
REQ-027 SHALL cover: flush with 500 entries and one read in flight -> next cycle count=0, empty=1, pop_valid=0; push 0x11 afterwards -> 0x11 is popped first.
REQ-028 SHALL cover: rst_n asserted mid-stream -> all outputs take REQ-017 values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sram_fifo_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : sram_fifo_pkg
// Purpose : Shared defaults and types for the SRAM-backed FIFO controller.
//           Holds the default data width, macro address width and macro
//           depth, plus the occupancy type of the 2-entry output buffer.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package sram_fifo_pkg;

   localparam int c_dw_default    = 8;
   localparam int c_aw_default    = 10;
   localparam int c_depth_default = 1024;

   // Occupancy of the output buffer: 0, 1 or 2 entries.
   typedef logic [1:0] buf_occ_t;

   localparam buf_occ_t c_buf_entries = 2'd2;

   // Number of buffer slots already spoken for: words held, plus a read
   // whose data lands at the end of this cycle, minus a word leaving now.
   function automatic logic [2:0] slots_committed(input buf_occ_t occ,
                                                  input logic     inflight,
                                                  input logic     popping);
      return 3'(occ) + 3'(inflight) - 3'(popping);
   endfunction

endpackage : sram_fifo_pkg
`default_nettype wire

// File: rtl/sram_fifo_outbuf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : sram_fifo_outbuf
// Purpose : 2-entry in-order output buffer sitting behind the SRAM read port.
//           The head word is presented from a register so it stays stable
//           while the consumer stalls.
// Ports   : clk, rst_n, flush       - clock, async active-low reset, sync clear
//           in_valid/in_ready/in_data    - write side (captured read data)
//           out_valid/out_ready/out_data - read side (FIFO head)
//           occupancy               - words currently held (0..2)
// Revision: 1.0 - initial release
// ============================================================================
module sram_fifo_outbuf
   import sram_fifo_pkg::*;
#(
   parameter int DW = c_dw_default
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output buf_occ_t      occupancy
);

   logic [DW-1:0] r_mem [2];
   logic          r_wr_idx;
   logic          r_rd_idx;
   buf_occ_t      r_occ;

   logic          w_wr;
   logic          w_rd;

   // When full, a word can still enter in the same cycle the head leaves:
   // the write slot is the one being vacated.
   assign in_ready  = (r_occ != c_buf_entries) || out_ready;
   assign out_valid = (r_occ != 2'd0);
   assign out_data  = r_mem[r_rd_idx];
   assign occupancy = r_occ;

   assign w_wr = in_valid && in_ready;
   assign w_rd = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_idx <= 1'b0;
         r_rd_idx <= 1'b0;
         r_occ    <= 2'd0;
      end else if (flush) begin
         r_wr_idx <= 1'b0;
         r_rd_idx <= 1'b0;
         r_occ    <= 2'd0;
      end else begin
         if (w_wr) begin
            r_mem[r_wr_idx] <= in_data;
            r_wr_idx        <= ~r_wr_idx;
         end
         if (w_rd) begin
            r_rd_idx <= ~r_rd_idx;
         end
         case ({w_wr, w_rd})
            2'b10:   r_occ <= r_occ + 2'd1;
            2'b01:   r_occ <= r_occ - 2'd1;
            default: r_occ <= r_occ;
         endcase
      end
   end

endmodule : sram_fifo_outbuf
`default_nettype wire

// File: rtl/sram_fifo_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : sram_fifo_ctrl
// Purpose : FIFO controller driving a dual-port (1W/1R) SRAM macro with a
//           1-cycle read latency. Writes go straight to the macro; reads are
//           issued ahead into a 2-entry output buffer so the consumer sees a
//           registered head and can pop every cycle. The macro itself is
//           instantiated by the parent, which also ties its clk0/clk1 to clk.
// Ports   : clk, rst_n, flush         - clock, async active-low reset, sync clear
//           push_valid/ready/data     - producer interface
//           pop_valid/ready/data      - consumer interface
//           count, empty, full        - status (count covers SRAM, in-flight
//                                       read and output buffer)
//           sram_csb0/addr0/din0      - macro write port
//           sram_csb1/addr1/dout1     - macro read port
// Revision: 1.0 - initial release
// ============================================================================
module sram_fifo_ctrl
   import sram_fifo_pkg::*;
#(
   parameter int DW    = c_dw_default,
   parameter int AW    = c_aw_default,
   parameter int DEPTH = c_depth_default
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          push_valid,
   output logic          push_ready,
   input  logic [DW-1:0] push_data,
   output logic          pop_valid,
   input  logic          pop_ready,
   output logic [DW-1:0] pop_data,
   output logic [AW:0]   count,
   output logic          empty,
   output logic          full,
   output logic          sram_csb0,
   output logic [AW-1:0] sram_addr0,
   output logic [DW-1:0] sram_din0,
   output logic          sram_csb1,
   output logic [AW-1:0] sram_addr1,
   input  logic [DW-1:0] sram_dout1
);

   localparam int            CW          = AW + 1;
   localparam logic [AW-1:0] c_ptr_last  = AW'(DEPTH - 1);
   localparam logic [CW-1:0] c_sram_full = CW'(DEPTH);

   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_sram_cnt;   // words in the macro not yet read out
   logic [CW-1:0] r_count;      // words owned by the FIFO as a whole
   logic          r_inflight;   // a read issued last cycle returns data now
   logic          r_run;        // low for the first edge after reset release

   buf_occ_t      w_ob_occ;
   logic          w_ob_in_valid;
   logic          w_ob_in_ready;
   logic          w_push;
   logic          w_pop;
   logic          w_rd_issue;
   logic          w_full;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == c_ptr_last) ? '0 : p + 1'b1;
   endfunction

   // ------------------------------------------------------------------------
   // Handshakes and read-issue decision
   // ------------------------------------------------------------------------
   assign w_full     = (r_sram_cnt == c_sram_full);
   assign push_ready = r_run && !w_full && !flush;
   assign w_push     = push_valid && push_ready;
   assign w_pop      = pop_valid && pop_ready;

   // A slot freed by a pop in this same cycle counts as available; without
   // that, a read could only be issued every other cycle and streaming
   // would stall. The macro count is registered, so a word written this
   // cycle cannot be read before the next one, after the macro has
   // committed it, and the read address can never equal the write address
   // while both ports are active.
   assign w_rd_issue = r_run && !flush && (r_sram_cnt != '0) &&
                       (slots_committed(w_ob_occ, r_inflight, w_pop) < 3'd2);

   // ------------------------------------------------------------------------
   // Macro ports
   // ------------------------------------------------------------------------
   assign sram_csb0  = !w_push;
   assign sram_addr0 = r_wptr;
   assign sram_din0  = push_data;
   assign sram_csb1  = !w_rd_issue;
   assign sram_addr1 = r_rptr;

   // ------------------------------------------------------------------------
   // Status
   // ------------------------------------------------------------------------
   assign count = r_count;
   assign empty = (r_count == '0);
   assign full  = w_full;

   // Read data from a read issued before a flush is dropped here. The
   // ready term is always true when a read is in flight, since issue only
   // happens with a slot reserved.
   assign w_ob_in_valid = r_inflight && !flush && w_ob_in_ready;

   // ------------------------------------------------------------------------
   // Pointers and counters
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_run      <= 1'b0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_sram_cnt <= '0;
         r_count    <= '0;
         r_inflight <= 1'b0;
      end else begin
         r_run <= 1'b1;
         if (flush) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_sram_cnt <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
         end else begin
            if (w_push) begin
               r_wptr <= ptr_inc(r_wptr);
            end
            if (w_rd_issue) begin
               r_rptr <= ptr_inc(r_rptr);
            end
            r_inflight <= w_rd_issue;

            case ({w_push, w_rd_issue})
               2'b10:   r_sram_cnt <= r_sram_cnt + 1'b1;
               2'b01:   r_sram_cnt <= r_sram_cnt - 1'b1;
               default: r_sram_cnt <= r_sram_cnt;
            endcase

            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + 1'b1;
               2'b01:   r_count <= r_count - 1'b1;
               default: r_count <= r_count;
            endcase
         end
      end
   end

   // ------------------------------------------------------------------------
   // Output buffer
   // ------------------------------------------------------------------------
   sram_fifo_outbuf #(
      .DW (DW)
   ) u_outbuf (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (w_ob_in_valid),
      .in_ready  (w_ob_in_ready),
      .in_data   (sram_dout1),
      .out_valid (pop_valid),
      .out_ready (pop_ready),
      .out_data  (pop_data),
      .occupancy (w_ob_occ)
   );

endmodule : sram_fifo_ctrl
`default_nettype wire
